// File: rtl/ifetch_pkg.sv
// ifetch_pkg: types and constants shared by the instruction-fetch stage.
//   XLEN / ILEN       : address and instruction widths
//   RESET_PC_DEFAULT  : first byte address fetched after reset
//   NOP_INSN          : encoding decode uses to fill bubbles (addi x0,x0,0)
//   fetch_entry_t     : one fetch-FIFO entry, {pc, insn}
package ifetch_pkg;
    localparam int          XLEN             = 32;
    localparam int          ILEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] insn;
    } fetch_entry_t;
endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: small first-word-fall-through FIFO between the ROM and decode.
//   clk, rst  : clock, asynchronous active-high reset
//   i_push    : write i_data at the tail
//   i_pop     : drop the head entry (ignored when empty)
//   i_flush   : discard all entries; wins over push and pop
//   o_valid   : head entry present
//   o_data    : head entry (zero when empty)
//   o_count   : number of stored entries
module ifetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic                       o_valid,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push & ~i_flush;
    assign w_pop  = i_pop & ~i_flush & (r_count != '0);

    // Storage carries no reset; the head is masked while empty instead.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (w_push && (r_wr_ptr == AW'(gi))) begin
                r_mem[gi] <= i_data;
            end
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    assign o_valid = (r_count != '0);
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;
endmodule

// File: rtl/ifetch.sv
// ifetch: instruction-fetch stage. Drives the ROM fetch port one word per
// cycle while FIFO credit remains, and presents {pc, insn} to decode.
//   clk, rst     : clock, asynchronous active-high reset
//   redirect     : load redirect_pc into the fetch PC and flush everything
//   redirect_pc  : new byte PC (bits [1:0] ignored)
//   out_valid    : head entry valid toward decode
//   out_ready    : decode accepts the head this cycle
//   out_pc       : byte PC of the head instruction
//   out_insn     : head instruction word
//   rom_oe       : ROM read enable
//   rom_addr     : ROM word address (fetch PC bits [SCALE+1:2])
//   rom_rdata    : ROM data, valid the cycle after rom_oe
module ifetch
    import ifetch_pkg::*;
#(
    parameter int          SCALE    = 10,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          QDEPTH   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_insn,
    output logic             rom_oe,
    output logic [SCALE-1:0] rom_addr,
    input  logic [31:0]      rom_rdata
);
    localparam int AW = $clog2(QDEPTH);

    logic [XLEN-1:0] r_fpc;
    logic [XLEN-1:0] r_req_pc;
    logic            r_run;
    logic            r_inflight;

    logic            w_pop;
    logic            w_issue;
    logic            w_push;
    logic [AW:0]     w_count;
    logic [AW+1:0]   w_credit;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;
    logic            w_unused;

    assign w_pop = out_valid & out_ready;

    // Entries held plus the one in flight, net of this cycle's pop, must
    // leave room for the word this cycle's read will return.
    assign w_credit = {1'b0, w_count} + (AW+2)'(r_inflight) - (AW+2)'(w_pop);
    assign w_issue  = r_run & ~redirect & (w_credit < (AW+2)'(QDEPTH));

    assign rom_oe   = w_issue;
    assign rom_addr = r_fpc[SCALE+1:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fpc      <= RESET_PC;
            r_req_pc   <= '0;
            r_run      <= 1'b0;
            r_inflight <= 1'b0;
        end else begin
            r_run      <= 1'b1;
            r_inflight <= w_issue;
            if (redirect) begin
                r_fpc <= {redirect_pc[31:2], 2'b00};
            end else if (w_issue) begin
                r_fpc    <= r_fpc + 32'd4;
                r_req_pc <= r_fpc;
            end
        end
    end

    // A response landing in a redirect cycle belongs to the old stream.
    assign w_push            = r_inflight & ~redirect;
    assign w_push_entry.pc   = r_req_pc;
    assign w_push_entry.insn = rom_rdata;

    ifetch_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .o_valid (out_valid),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign out_pc   = w_head.pc;
    assign out_insn = w_head.insn;

    assign w_unused = &{1'b0, redirect_pc[1:0]};
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed bench for ifetch with a registered-read ROM model
// holding ROM[k] = k + 0x100.
module tb_ifetch;
    localparam int SCALE  = 10;
    localparam int QDEPTH = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [31:0]      out_insn;
    logic             rom_oe;
    logic [SCALE-1:0] rom_addr;
    logic [31:0]      rom_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ifetch #(
        .SCALE    (SCALE),
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (QDEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_insn    (out_insn),
        .rom_oe      (rom_oe),
        .rom_addr    (rom_addr),
        .rom_rdata   (rom_rdata)
    );

    always @(posedge clk) begin
        if (rom_oe) begin
            rom_rdata <= 32'h100 + {22'd0, rom_addr};
        end
    end

    // Occupancy must never exceed the FIFO depth.
    always @(negedge clk) begin
        if (!rst) begin
            n_tests++;
            assert (32'(dut.w_count) <= QDEPTH) else begin
                n_fail++;
                $error("FAIL fifo_count observed=%0d expected<=%0d", dut.w_count, QDEPTH);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        $display("[TB] check %s observed=%h expected=%h", tag, obs, exp);
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        out_ready   = 1'b1;
        rom_rdata   = 32'h0;
        repeat (2) tick();
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_oe",    {31'd0, rom_oe},    32'd0);
        chk("rst_pc",    out_pc,             32'd0);
        chk("rst_insn",  out_insn,           32'd0);

        // Release reset; the first edge only sets run.
        rst = 1'b0;
        #1;
        chk("prerun_oe", {31'd0, rom_oe}, 32'd0);
        tick(); #1;
        chk("c1_oe",    {31'd0, rom_oe},    32'd1);
        chk("c1_addr",  {22'd0, rom_addr},  32'd0);
        chk("c1_valid", {31'd0, out_valid}, 32'd0);
        tick(); #1;
        chk("c2_oe",    {31'd0, rom_oe},    32'd1);
        chk("c2_addr",  {22'd0, rom_addr},  32'd1);
        chk("c2_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick(); #1;
            chk("strm_valid", {31'd0, out_valid}, 32'd1);
            chk("strm_pc",    out_pc,             32'(4 * i));
            chk("strm_insn",  out_insn,           32'h100 + 32'(i));
            chk("strm_addr",  {22'd0, rom_addr},  32'(i + 2));
        end

        // Backpressure for five cycles: head 0x18 must hold.
        tick();
        out_ready = 1'b0;
        #1;
        chk("bp0_pc",   out_pc,          32'h18);
        chk("bp0_insn", out_insn,        32'h106);
        chk("bp0_oe",   {31'd0, rom_oe}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_pc",    out_pc,             32'h18);
            chk("bp_insn",  out_insn,           32'h106);
            chk("bp_oe",    {31'd0, rom_oe},    32'd0);
        end
        tick();
        out_ready = 1'b1;
        #1;
        chk("rel_pc",   out_pc,            32'h18);
        chk("rel_oe",   {31'd0, rom_oe},   32'd1);
        chk("rel_addr", {22'd0, rom_addr}, 32'd8);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("rel_valid", {31'd0, out_valid}, 32'd1);
            chk("rel_seq_pc",   out_pc,   32'h1c + 32'(4 * i));
            chk("rel_seq_insn", out_insn, 32'h107 + 32'(i));
        end

        // Redirect to 0x40 while head 0x24 is popped and 0x28 is in flight.
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        #1;
        chk("rd1_oe",    {31'd0, rom_oe},    32'd0);
        chk("rd1_valid", {31'd0, out_valid}, 32'd1);
        tick();
        redirect = 1'b0;
        #1;
        chk("rd1_r1_valid", {31'd0, out_valid}, 32'd0);
        chk("rd1_r1_oe",    {31'd0, rom_oe},    32'd1);
        chk("rd1_r1_addr",  {22'd0, rom_addr},  32'h10);
        tick(); #1;
        chk("rd1_r2_valid", {31'd0, out_valid}, 32'd0);
        chk("rd1_r2_addr",  {22'd0, rom_addr},  32'h11);
        tick(); #1;
        chk("rd1_r3_valid", {31'd0, out_valid}, 32'd1);
        chk("rd1_r3_pc",    out_pc,             32'h40);
        chk("rd1_r3_insn",  out_insn,           32'h110);
        tick(); #1;
        chk("rd1_r4_pc",    out_pc,             32'h44);
        chk("rd1_r4_insn",  out_insn,           32'h111);

        // Fill the FIFO, then redirect to an unaligned, aliasing address.
        tick();
        out_ready = 1'b0;
        #1;
        chk("fill0_pc", out_pc,          32'h48);
        chk("fill0_oe", {31'd0, rom_oe}, 32'd0);
        tick(); #1;
        chk("fill1_pc", out_pc,          32'h48);
        chk("fill1_oe", {31'd0, rom_oe}, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_1003;
        #1;
        chk("rd2_oe", {31'd0, rom_oe}, 32'd0);
        tick();
        redirect  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rd2_r1_valid", {31'd0, out_valid}, 32'd0);
        chk("rd2_r1_oe",    {31'd0, rom_oe},    32'd1);
        chk("rd2_r1_addr",  {22'd0, rom_addr},  32'h000);
        tick(); #1;
        chk("rd2_r2_valid", {31'd0, out_valid}, 32'd0);
        chk("rd2_r2_addr",  {22'd0, rom_addr},  32'h001);
        tick(); #1;
        chk("rd2_r3_valid", {31'd0, out_valid}, 32'd1);
        chk("rd2_r3_pc",    out_pc,             32'h0000_1000);
        chk("rd2_r3_insn",  out_insn,           32'h100);
        tick(); #1;
        chk("rd2_r4_pc",    out_pc,             32'h0000_1004);
        chk("rd2_r4_insn",  out_insn,           32'h101);

        // Fill the FIFO again, then pulse reset mid-cycle.
        tick();
        out_ready = 1'b0;
        #1;
        chk("full0_pc",   out_pc,          32'h0000_1008);
        chk("full0_insn", out_insn,        32'h102);
        tick(); #1;
        chk("full1_valid", {31'd0, out_valid}, 32'd1);
        chk("full1_oe",    {31'd0, rom_oe},    32'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_oe",    {31'd0, rom_oe},    32'd0);
        chk("arst_pc",    out_pc,             32'd0);
        chk("arst_insn",  out_insn,           32'd0);
        tick();
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rs_prerun_oe", {31'd0, rom_oe}, 32'd0);
        tick(); #1;
        chk("rs_c1_oe",    {31'd0, rom_oe},    32'd1);
        chk("rs_c1_addr",  {22'd0, rom_addr},  32'd0);
        chk("rs_c1_valid", {31'd0, out_valid}, 32'd0);
        tick(); #1;
        chk("rs_c2_addr",  {22'd0, rom_addr},  32'd1);
        chk("rs_c2_valid", {31'd0, out_valid}, 32'd0);
        tick(); #1;
        chk("rs_c3_valid", {31'd0, out_valid}, 32'd1);
        chk("rs_c3_pc",    out_pc,             32'd0);
        chk("rs_c3_insn",  out_insn,           32'h100);
        tick(); #1;
        chk("rs_c4_pc",    out_pc,             32'd4);
        chk("rs_c4_insn",  out_insn,           32'h101);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
